q_table_update: RTL and testbench

Write-side partner to the greedy action selector: owns the 37×4 Q-table register array and applies the Q-learning update Q(s,a) ← Q(s,a) + α·(r + γ·maxQ(s′) − Q(s,a)) for one (state, action) pair per request. The full table is exported combinationally for read-side blocks. The best next-state value arrives from the selector's max_Q output. Requests arrive from the agent controller after each completed maze move. Completion is reported with a one-cycle done pulse.

---
 rtl/q_learn_pkg.sv | 25 ++
 rtl/q_update_alu.sv | 48 ++++
 rtl/q_table_update.sv | 125 ++++++++++++
 tb/tb_q_table_update.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_learn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : q_learn_pkg
//  Description : Shared Q-learning constants, Q16.16 limits and FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package q_learn_pkg;

    localparam int N_STATES  = 37;
    localparam int N_ACTIONS = 4;
    localparam int Q_W       = 32;

    localparam logic signed [Q_W-1:0] Q_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [Q_W-1:0] Q_MIN = 32'sh8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CALC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } q_state_t;

endpackage
`default_nettype wire

// File: rtl/q_update_alu.sv
`default_nettype none
// ============================================================================
//  Module      : q_update_alu
//  Description : Combinational Q-learning update q + a*(r + g*maxQ - q), saturated.
//  Revision    : 1.0  initial release
// ============================================================================
module q_update_alu
    import q_learn_pkg::*;
#(
    parameter int ALPHA_SHIFT = 1,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic [Q_W-1:0] i_q,
    input  logic [Q_W-1:0] i_reward,
    input  logic [Q_W-1:0] i_next_max_q,
    output logic [Q_W-1:0] o_q_new
);

    localparam logic signed [Q_W+2:0] c_sum_max = {{3{Q_MAX[Q_W-1]}}, Q_MAX};
    localparam logic signed [Q_W+2:0] c_sum_min = {{3{Q_MIN[Q_W-1]}}, Q_MIN};

    logic signed [Q_W:0]   w_nmq;
    logic signed [Q_W:0]   w_gq;
    logic signed [Q_W:0]   w_target;
    logic signed [Q_W+1:0] w_err;
    logic signed [Q_W+1:0] w_delta;
    logic signed [Q_W+2:0] w_sum;

    always_comb begin
        w_nmq    = {i_next_max_q[Q_W-1], i_next_max_q};
        w_gq     = w_nmq - (w_nmq >>> GAMMA_SHIFT);
        w_target = {i_reward[Q_W-1], i_reward} + w_gq;
        w_err    = {w_target[Q_W], w_target} - {{2{i_q[Q_W-1]}}, i_q};
        // Arithmetic shift floors toward minus infinity for negative errors.
        w_delta  = w_err >>> ALPHA_SHIFT;
        w_sum    = {{3{i_q[Q_W-1]}}, i_q} + {w_delta[Q_W+1], w_delta};

        if (w_sum > c_sum_max) begin
            o_q_new = Q_MAX;
        end else if (w_sum < c_sum_min) begin
            o_q_new = Q_MIN;
        end else begin
            o_q_new = w_sum[Q_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/q_table_update.sv
`default_nettype none
// ============================================================================
//  Module      : q_table_update
//  Description : Owns the 37x4 Q-table and applies one Q-learning update per request.
//  Revision    : 1.0  initial release
// ============================================================================
module q_table_update
    import q_learn_pkg::*;
#(
    parameter int ALPHA_SHIFT = 1,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clr,
    input  logic [5:0]           maze_state,
    input  logic [3:0]           action,
    input  logic [Q_W-1:0]       reward,
    input  logic [Q_W-1:0]       next_max_Q,
    output logic [Q_W-1:0]       q_table [N_STATES][N_ACTIONS],
    output logic                 busy,
    output logic                 done_o,
    output logic                 err_o
);

    q_state_t        r_state;
    logic [5:0]      r_s;
    logic [3:0]      r_a;
    logic [Q_W-1:0]  r_reward;
    logic [Q_W-1:0]  r_nmq;
    logic [Q_W-1:0]  r_q;
    logic [Q_W-1:0]  r_sum;
    logic            r_err_flag;
    logic [Q_W-1:0]  r_table [N_STATES][N_ACTIONS];
    logic [Q_W-1:0]  w_q_new;

    q_update_alu #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .GAMMA_SHIFT (GAMMA_SHIFT)
    ) u_alu (
        .i_q          (r_q),
        .i_reward     (r_reward),
        .i_next_max_q (r_nmq),
        .o_q_new      (w_q_new)
    );

    assign q_table = r_table;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_STATES; s++) begin
                for (int a = 0; a < N_ACTIONS; a++) begin
                    r_table[s][a] <= '0;
                end
            end
            r_state    <= ST_IDLE;
            r_s        <= '0;
            r_a        <= '0;
            r_reward   <= '0;
            r_nmq      <= '0;
            r_q        <= '0;
            r_sum      <= '0;
            r_err_flag <= 1'b0;
            busy       <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clr) begin
                        for (int s = 0; s < N_STATES; s++) begin
                            for (int a = 0; a < N_ACTIONS; a++) begin
                                r_table[s][a] <= '0;
                            end
                        end
                    end else if (start) begin
                        r_s      <= maze_state;
                        r_a      <= action;
                        r_reward <= reward;
                        r_nmq    <= next_max_Q;
                        busy     <= 1'b1;
                        r_state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    // A rejected request still passes through WRITE (write inhibited)
                    // so that its done pulse lands one cycle after the check.
                    if (r_s >= 6'(N_STATES) || r_a >= 4'(N_ACTIONS)) begin
                        r_err_flag <= 1'b1;
                        r_state    <= ST_WRITE;
                    end else begin
                        r_err_flag <= 1'b0;
                        r_q        <= r_table[r_s][r_a[1:0]];
                        r_state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_sum   <= w_q_new;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (!r_err_flag) begin
                        r_table[r_s][r_a[1:0]] <= r_sum;
                    end
                    done_o  <= 1'b1;
                    err_o   <= r_err_flag;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_q_table_update.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q_table_update
//  Description : Randomised self-checking bench for q_table_update with a Q16.16 model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_q_table_update;
    import q_learn_pkg::*;

    localparam int ALPHA_SHIFT = 1;
    localparam int GAMMA_SHIFT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clr = 1'b0;
    logic [5:0]  maze_state = '0;
    logic [3:0]  action = '0;
    logic [31:0] reward = '0;
    logic [31:0] next_max_Q = '0;
    logic [31:0] q_table [N_STATES][N_ACTIONS];
    logic        busy;
    logic        done_o;
    logic        err_o;

    q_table_update #(
        .ALPHA_SHIFT (ALPHA_SHIFT),
        .GAMMA_SHIFT (GAMMA_SHIFT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clr        (clr),
        .maze_state (maze_state),
        .action     (action),
        .reward     (reward),
        .next_max_Q (next_max_Q),
        .q_table    (q_table),
        .busy       (busy),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [N_STATES][N_ACTIONS];
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_err  = 1'b0;

    // Floor division by 2^k on plain integers.
    function automatic longint floor_div_pow2(input longint x, input int k);
        longint d;
        d = longint'(1) << k;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic logic [31:0] model_update(input logic [31:0] q, input logic [31:0] r,
                                                 input logic [31:0] m);
        longint qv, rv, mv, target, sum;
        qv     = longint'($signed(q));
        rv     = longint'($signed(r));
        mv     = longint'($signed(m));
        target = rv + (mv - floor_div_pow2(mv, GAMMA_SHIFT));
        sum    = qv + floor_div_pow2(target - qv, ALPHA_SHIFT);
        if (sum > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (sum < -64'sd2147483648) return 32'h8000_0000;
        return sum[31:0];
    endfunction

    always @(negedge clk) begin : cmp
        int  fs, fa;
        bit  found;
        found = 1'b0;
        fs = 0;
        fa = 0;
        for (int s = 0; s < N_STATES; s++) begin
            for (int a = 0; a < N_ACTIONS; a++) begin
                if (!found && q_table[s][a] !== exp_q[s][a]) begin
                    found = 1'b1;
                    fs = s;
                    fa = a;
                end
            end
        end
        total++;
        if (found) begin
            bad++;
            $display("FAIL table[%0d][%0d] t=%0t got=%h want=%h", fs, fa, $time,
                     q_table[fs][fa], exp_q[fs][fa]);
        end
        total++;
        if (busy !== exp_busy) begin
            bad++;
            $display("FAIL busy t=%0t got=%b want=%b", $time, busy, exp_busy);
        end
        total++;
        if (done_o !== exp_done) begin
            bad++;
            $display("FAIL done_o t=%0t got=%b want=%b", $time, done_o, exp_done);
        end
        if (exp_done || rst) begin
            total++;
            if (err_o !== exp_err) begin
                bad++;
                $display("FAIL err_o t=%0t got=%b want=%b", $time, err_o, exp_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic zero_model();
        for (int s = 0; s < N_STATES; s++)
            for (int a = 0; a < N_ACTIONS; a++)
                exp_q[s][a] = '0;
    endtask

    task automatic run_update(input logic [5:0] s, input logic [3:0] a, input logic [31:0] r,
                              input logic [31:0] m, input bit poke);
        bit          rejected;
        logic [31:0] newv;
        rejected   = (int'(s) >= N_STATES) || (int'(a) >= N_ACTIONS);
        maze_state = s;
        action     = a;
        reward     = r;
        next_max_Q = m;
        start      = 1'b1;
        clr        = 1'b0;
        tick();                                   // accepting edge N
        exp_busy   = 1'b1;
        start      = poke;
        clr        = poke;
        maze_state = 6'($urandom);
        action     = 4'($urandom);
        reward     = $urandom;
        next_max_Q = $urandom;
        tick();                                   // N+1
        start = 1'b0;
        clr   = 1'b0;
        if (rejected) begin
            tick();                               // N+2
            exp_done = 1'b1;
            exp_err  = 1'b1;
            tick();                               // N+3
            exp_done = 1'b0;
            exp_err  = 1'b0;
            exp_busy = 1'b0;
        end else begin
            newv = model_update(exp_q[s][a[1:0]], r, m);
            tick();                               // N+2
            tick();                               // N+3
            exp_q[s][a[1:0]] = newv;
            exp_done = 1'b1;
            exp_err  = 1'b0;
            tick();                               // N+4
            exp_done = 1'b0;
            exp_busy = 1'b0;
        end
    endtask

    task automatic run_clear(input bit with_start);
        clr        = 1'b1;
        start      = with_start;
        maze_state = 6'($urandom_range(0, 36));
        action     = 4'($urandom_range(0, 3));
        tick();
        clr   = 1'b0;
        start = 1'b0;
        zero_model();
        tick();
    endtask

    task automatic run_reset_in_calc(input logic [5:0] s, input logic [3:0] a,
                                     input logic [31:0] r, input logic [31:0] m);
        maze_state = s;
        action     = a;
        reward     = r;
        next_max_Q = m;
        start      = 1'b1;
        tick();                                   // N: to READ
        exp_busy = 1'b1;
        start    = 1'b0;
        tick();                                   // N+1: in CALC
        #2;
        rst = 1'b1;
        zero_model();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        logic [31:0] rr, mm;
        int          kind;
        zero_model();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        run_update(6'd5, 4'd2, 32'h0001_0000, 32'h0008_0000, 1'b0);
        check_lit("q52", q_table[5][2], 32'h0004_0000);

        run_update(6'd0, 4'd1, 32'h0004_0000, 32'h0000_0000, 1'b0);
        check_lit("q01_preset", q_table[0][1], 32'h0002_0000);
        run_update(6'd0, 4'd1, 32'hFFFF_0000, 32'h0000_0000, 1'b0);
        check_lit("q01_neg", q_table[0][1], 32'h0000_8000);

        run_update(6'd36, 4'd3, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0);
        check_lit("q363_step1", q_table[36][3], 32'h77FF_1000);
        run_update(6'd36, 4'd3, 32'h79FE_F000, 32'h1000_0000, 1'b0);
        check_lit("q363_preset", q_table[36][3], 32'h7FFF_0000);
        run_update(6'd36, 4'd3, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0);
        check_lit("sat_pos", q_table[36][3], 32'h7FFF_FFFF);

        run_update(6'd1, 4'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check_lit("q10_step1", q_table[1][0], 32'h8800_0000);
        run_update(6'd1, 4'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check_lit("sat_neg", q_table[1][0], 32'h8000_0000);

        run_update(6'd37, 4'd0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        run_update(6'd3, 4'd4, 32'h0001_0000, 32'h0001_0000, 1'b1);
        run_update(6'd7, 4'd1, 32'h0003_0000, 32'h0002_0000, 1'b1);
        check_lit("poke_keep", q_table[5][2], 32'h0004_0000);

        run_clear(1'b1);
        check_lit("clr_363", q_table[36][3], 32'h0000_0000);

        run_update(6'd10, 4'd2, 32'h0003_0000, 32'h0000_0000, 1'b0);
        run_reset_in_calc(6'd10, 4'd2, 32'h0005_0000, 32'h0001_0000);
        check_lit("rst_102", q_table[10][2], 32'h0000_0000);

        for (int i = 0; i < 120; i++) begin
            kind = $urandom_range(0, 99);
            rr = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(8'($urandom)) <<< 16);
            mm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(8'($urandom)) <<< 16);
            if (kind < 75) begin
                run_update(6'($urandom_range(0, 36)), 4'($urandom_range(0, 3)), rr, mm,
                           1'($urandom_range(0, 1)));
            end else if (kind < 90) begin
                if ($urandom_range(0, 1) == 1)
                    run_update(6'($urandom_range(37, 63)), 4'($urandom_range(0, 15)), rr, mm, 1'b0);
                else
                    run_update(6'($urandom_range(0, 36)), 4'($urandom_range(4, 15)), rr, mm, 1'b1);
            end else if (kind < 94) begin
                run_clear(1'($urandom_range(0, 1)));
            end else begin
                tick();
            end
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
